fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Multi-cycle instruction fetch and control sequencer that sits directly upstream of the pc block.
- Requests the instruction at the current pc and latches it into the instruction register.
- Evaluates the Bcond/Jcond/JAL condition against the PSR flags.
- Drives pc's pcEn/branch/jump/disp/dSrc for exactly one cycle per instruction; for JAL it also commands the link write of pc_ra.

Parameters:
- TRAP_VEC, 16'hFFF0, jump target for illegal opcodes (used only with ILLEGAL_TRAP_EN).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- instr_in  in  16  instruction word returned by memory for the current pc.
- instr_valid  in  1  instr_in valid this cycle; sampled only in FETCH.
- flags  in  5  PSR {C,L,F,Z,N}; sampled only in DECODE.
- rtarget  in  16  register-file read of Rtarget (ir[3:0]).
- stall  in  1  datapath busy (load/store in progress); honoured only in EXEC.
- fetch_req  out  1  instruction read request at current pc.
- ir  out  16  instruction register.
- pcEn  out  1  pc update enable to pc.
- branch  out  1  select pc+disp to pc.
- jump  out  1  select dSrc to pc.
- disp  out  8  branch displacement to pc (ir[7:0]).
- dSrc  out  16  jump target to pc.
- link_we  out  1  write pc_ra into Rlink (ir[11:8]).
- exec_en  out  1  datapath execute strobe for non-control instructions.
- state  out  2  current FSM state (debug).

Behaviour:
- States: FETCH=2'd0, DECODE=2'd1, EXEC=2'd2. 2'd3 is illegal and returns to FETCH on the next clock.
- rst low (async): state=FETCH, ir=16'h0000, taken=0. While rst is low, every output is 0, including fetch_req, which is gated by rst.
- FETCH:
  - fetch_req=1.
  - If instr_valid=1: ir<=instr_in and go to DECODE; otherwise hold in FETCH indefinitely.
- DECODE:
  - One cycle. Register taken<=cond(ir[11:8], flags), then go to EXEC.
  - Decode fields: opcode ir[15:12], opext ir[7:4].
  - Bcond: opcode 4'hC.
  - Jcond: opcode 4'h4, opext 4'hC.
  - JAL: opcode 4'h4, opext 4'h8.
- Condition table (cond, flag term):
  - EQ 0000: Z.
  - NE 0001: !Z.
  - CS 0010: C.
  - CC 0011: !C.
  - HI 0100: L.
  - LS 0101: !L.
  - GT 0110: N.
  - LE 0111: !N.
  - FS 1000: F.
  - FC 1001: !F.
  - LO 1010: !L&!Z.
  - HS 1011: L|Z.
  - LT 1100: !N&!Z.
  - GE 1101: N|Z.
  - UC 1110: 1.
  - 1111: 0.
- EXEC:
  - Outputs are combinational from state, ir, taken and rtarget.
  - Outputs are asserted only when stall=0; while stall=1, hold EXEC with all outputs 0.
  - On the stall=0 cycle, go to FETCH, and pc updates on that same edge.
- EXEC output cases:
  - Bcond taken: pcEn=1, branch=1, disp=ir[7:0].
  - Bcond not taken: pcEn=1 only (pc+1).
  - Jcond taken: pcEn=1, jump=1, dSrc=rtarget.
  - Jcond not taken: pcEn=1 only.
  - JAL: pcEn=1, jump=1, dSrc=rtarget, link_we=1, unconditional. The link value is pc_ra of the current pc.
  - All others: pcEn=1, exec_en=1.
- Outside EXEC: pcEn, branch, jump, link_we and exec_en are 0; disp and dSrc are 0.
- Latency: minimum 3 cycles per instruction (valid in the first FETCH cycle, no stall).
- Boundaries:
  - instr_valid in DECODE/EXEC is ignored.
  - stall in FETCH/DECODE is ignored.
  - Reset asserted mid-EXEC aborts the instruction with no pcEn pulse.
  - branch and jump are never both 1.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: opcodes 4'h7 and 4'hA are illegal. In EXEC they drive pcEn=1, jump=1, dSrc=TRAP_VEC, with exec_en=0 and link_we=0.
- Undefined: opcodes 4'h7 and 4'hA are treated like any other non-control instruction (pcEn=1, exec_en=1).

Test Plan:
- Reset, then instr_valid=1 with instr_in=16'h5101 -> fetch_req=1 in cycle 0, ir=16'h5101 after cycle 0, exec_en=1 and pcEn=1 in cycle 2 only, fetch_req=1 again in cycle 3.
- instr_in=16'hC07F, flags Z=1 -> EXEC: pcEn=1, branch=1, disp=8'h7F. Repeat with Z=0 -> pcEn=1, branch=0, jump=0.
- instr_in=16'h4EC3 (UC Jcond), rtarget=16'h8000 -> EXEC: pcEn=1, jump=1, dSrc=16'h8000. With cond 1111 -> jump=0.
- instr_in=16'h4F83 (JAL), rtarget=16'hFFFF -> EXEC: jump=1, dSrc=16'hFFFF, link_we=1 for exactly one cycle.
- Non-control instruction with stall=1 for 4 cycles in EXEC -> pcEn=0 for those 4 cycles, then a single pcEn=1 cycle. Separately, rst low mid-EXEC -> all outputs 0 immediately and state=FETCH.
- ILLEGAL_TRAP_EN defined, instr_in=16'h7000 -> EXEC: jump=1, dSrc=16'hFFF0, exec_en=0. Undefined -> exec_en=1.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Multi-cycle fetch/decode/exec sequencer feeding the pc block; one pc update per instruction.
// Optional macro ILLEGAL_TRAP_EN: opcodes 4'h7/4'hA jump to TRAP_VEC instead of executing.
module fetch_ctrl #(
    parameter logic [15:0] TRAP_VEC = 16'hFFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic        instr_valid,
    input  logic [4:0]  flags,
    input  logic [15:0] rtarget,
    input  logic        stall,
    output logic        fetch_req,
    output logic [15:0] ir,
    output logic        pcEn,
    output logic        branch,
    output logic        jump,
    output logic [7:0]  disp,
    output logic [15:0] dSrc,
    output logic        link_we,
    output logic        exec_en,
    output logic [1:0]  state
);
    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [1:0]  state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        taken_q, taken_d;

    // flags packing is {C,L,F,Z,N}
    function automatic logic cond_eval(input logic [3:0] c, input logic [4:0] f);
        logic fc, fl, ff, fz, fn;
        {fc, fl, ff, fz, fn} = f;
        case (c)
            4'h0: cond_eval = fz;
            4'h1: cond_eval = !fz;
            4'h2: cond_eval = fc;
            4'h3: cond_eval = !fc;
            4'h4: cond_eval = fl;
            4'h5: cond_eval = !fl;
            4'h6: cond_eval = fn;
            4'h7: cond_eval = !fn;
            4'h8: cond_eval = ff;
            4'h9: cond_eval = !ff;
            4'hA: cond_eval = !fl && !fz;
            4'hB: cond_eval = fl || fz;
            4'hC: cond_eval = !fn && !fz;
            4'hD: cond_eval = fn || fz;
            4'hE: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    logic [3:0] opcode, opext;
    logic       is_bcond, is_jcond, is_jal, is_illegal;

    assign opcode     = ir_q[15:12];
    assign opext      = ir_q[7:4];
    assign is_bcond   = (opcode == 4'hC);
    assign is_jcond   = (opcode == 4'h4) && (opext == 4'hC);
    assign is_jal     = (opcode == 4'h4) && (opext == 4'h8);
    assign is_illegal = TRAP_EN && ((opcode == 4'h7) || (opcode == 4'hA));

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        taken_d = taken_q;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                taken_d = cond_eval(ir_q[11:8], flags);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (!stall) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            ir_q    <= 16'h0000;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            taken_q <= taken_d;
        end
    end

    // The pc-facing strobes fire only on the single non-stalled EXEC cycle.
    always_comb begin
        fetch_req = rst && (state_q == S_FETCH);
        pcEn      = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        disp      = 8'h00;
        dSrc      = 16'h0000;
        link_we   = 1'b0;
        exec_en   = 1'b0;
        if (rst && (state_q == S_EXEC) && !stall) begin
            pcEn = 1'b1;
            if (is_bcond) begin
                if (taken_q) begin
                    branch = 1'b1;
                    disp   = ir_q[7:0];
                end
            end else if (is_jcond) begin
                if (taken_q) begin
                    jump = 1'b1;
                    dSrc = rtarget;
                end
            end else if (is_jal) begin
                jump    = 1'b1;
                dSrc    = rtarget;
                link_we = 1'b1;
            end else if (is_illegal) begin
                jump = 1'b1;
                dSrc = TRAP_VEC;
            end else begin
                exec_en = 1'b1;
            end
        end
    end

    assign ir    = ir_q;
    assign state = state_q;
endmodule
